// File: rtl/weight_bank.sv
// weight_bank: double-buffered weight store. Streamed loads fill a shadow bank that is
// copied to the active bank in a single cycle once a complete, well-formed sequence arrives.
module weight_bank #(
    parameter int unsigned N_NEURONS = 4,
    parameter int unsigned N_INPUTS  = 8,
    parameter int unsigned W_WIDTH   = 8,
    parameter logic [N_NEURONS*N_INPUTS*W_WIDTH-1:0] INIT = '0
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               load_valid,
    output logic                                               load_ready,
    input  logic [W_WIDTH-1:0]                                 load_data,
    input  logic                                               load_last,
    input  logic                                               load_abort,
    output logic                                               load_done,
    output logic                                               load_err,
    output logic [N_NEURONS*N_INPUTS*W_WIDTH-1:0]              weights,
    input  logic                                               rd_en,
    input  logic [((N_NEURONS > 1) ? $clog2(N_NEURONS) : 1)-1:0] rd_row,
    output logic [N_INPUTS*W_WIDTH-1:0]                        rd_data,
    output logic                                               rd_valid
);

    localparam int unsigned TOTAL     = N_NEURONS * N_INPUTS;
    localparam int unsigned CNT_W     = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int unsigned ROW_BITS  = N_INPUTS * W_WIDTH;
    localparam int unsigned BANK_BITS = TOTAL * W_WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StCommit
    } state_t;

    state_t                 r_state;
    state_t                 w_state_d;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_d;
    logic                   w_err_d;
    logic                   w_done_d;
    logic                   w_shadow_we;
    logic                   r_load_done;
    logic                   r_load_err;
    logic [BANK_BITS-1:0]   r_active;
    logic [BANK_BITS-1:0]   r_shadow;
    logic [BANK_BITS-1:0]   w_rd_src;
    logic [ROW_BITS-1:0]    w_rd_row;
    logic [ROW_BITS-1:0]    r_rd_data;
    logic                   r_rd_valid;

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_err_d     = 1'b0;
        w_done_d    = 1'b0;
        w_shadow_we = 1'b0;
        unique case (r_state)
            StIdle, StFill: begin
                if (load_abort) begin
                    // An aborting beat is consumed but never written.
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end else if (load_valid) begin
                    w_shadow_we = 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_d = '0;
                        if (load_last) begin
                            w_state_d = StCommit;
                        end else begin
                            w_state_d = StIdle;
                            w_err_d   = 1'b1;
                        end
                    end else if (load_last) begin
                        w_state_d = StIdle;
                        w_cnt_d   = '0;
                        w_err_d   = 1'b1;
                    end else begin
                        w_state_d = StFill;
                        w_cnt_d   = r_cnt + CNT_W'(1);
                    end
                end
            end
            StCommit: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
                w_done_d  = 1'b1;
            end
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_load_done <= w_done_d;
            r_load_err  <= w_err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= INIT;
            r_shadow <= INIT;
        end else begin
            if (w_shadow_we) begin
                for (int k = 0; k < int'(TOTAL); k++) begin
                    if (r_cnt == CNT_W'(k)) begin
                        r_shadow[k*W_WIDTH +: W_WIDTH] <= load_data;
                    end
                end
            end
            if (r_state == StCommit) begin
                r_active <= r_shadow;
            end
        end
    end

    // During the commit cycle the shadow bank is what active becomes, so reads see it.
    assign w_rd_src = (r_state == StCommit) ? r_shadow : r_active;

    always_comb begin
        w_rd_row = '0;
        for (int r = 0; r < int'(N_NEURONS); r++) begin
            if (int'(rd_row) == r) begin
                w_rd_row = w_rd_src[r*ROW_BITS +: ROW_BITS];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_row;
            end
        end
    end

    assign load_ready = (r_state != StCommit);
    assign load_done  = r_load_done;
    assign load_err   = r_load_err;
    assign weights    = r_active;
    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;

endmodule

// File: tb/tb_weight_bank.sv
// tb_weight_bank: randomized load/read traffic against a queue-based reference model,
// plus directed load, error, abort, commit-cycle read and reset scenarios.
module tb_weight_bank;

    localparam int NN  = 4;
    localparam int NI  = 8;
    localparam int TOT = NN * NI;
    localparam logic [79:0] INIT2 = 80'hA1B2_C3D4_E5F6_0718_293A;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_valid = 1'b0;
    logic         load_last  = 1'b0;
    logic         load_abort = 1'b0;
    logic [7:0]   load_data  = '0;
    logic         load_ready, load_done, load_err, rd_valid;
    logic [255:0] weights;
    logic         rd_en = 1'b0;
    logic [1:0]   rd_row = '0;
    logic [63:0]  rd_data;

    logic         l2_valid = 1'b0;
    logic         l2_last  = 1'b0;
    logic [7:0]   l2_data  = '0;
    logic         l2_ready, l2_done, l2_err, rd2_valid;
    logic [79:0]  weights2;
    logic         rd2_en = 1'b0;
    logic [2:0]   rd2_row = '0;
    logic [15:0]  rd2_data;

    weight_bank #(.N_NEURONS(NN), .N_INPUTS(NI), .W_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_last(load_last), .load_abort(load_abort),
        .load_done(load_done), .load_err(load_err), .weights(weights), .rd_en(rd_en),
        .rd_row(rd_row), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    // Odd geometry with non-zero reset contents; rd_row is wide enough to go out of range.
    weight_bank #(.N_NEURONS(5), .N_INPUTS(2), .W_WIDTH(8), .INIT(INIT2)) u_dut2 (
        .clk(clk), .rst(rst), .load_valid(l2_valid), .load_ready(l2_ready),
        .load_data(l2_data), .load_last(l2_last), .load_abort(1'b0),
        .load_done(l2_done), .load_err(l2_err), .weights(weights2), .rd_en(rd2_en),
        .rd_row(rd2_row), .rd_data(rd2_data), .rd_valid(rd2_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: a load is the list of beats accepted since the last boundary.
    logic [7:0]  m_active[TOT];
    logic [7:0]  m_staged[TOT];
    logic [7:0]  q[$];
    bit          m_pend = 1'b0;
    logic        exp_ready = 1'b1;
    logic        exp_done = 1'b0;
    logic        exp_err = 1'b0;
    logic        exp_rd_valid = 1'b0;
    logic [63:0] exp_rd_data = '0;

    initial foreach (m_active[k]) m_active[k] = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            foreach (m_active[k]) m_active[k] = '0;
            q.delete();
            m_pend = 1'b0;
            exp_ready = 1'b1;
            exp_done = 1'b0;
            exp_err = 1'b0;
            exp_rd_valid = 1'b0;
            exp_rd_data = '0;
        end else begin
            exp_done = 1'b0;
            exp_err  = 1'b0;
            if (m_pend) begin
                m_active = m_staged;
                m_pend   = 1'b0;
                exp_done = 1'b1;
            end else if (load_abort) begin
                q.delete();
            end else if (load_valid) begin
                q.push_back(load_data);
                if (q.size() == TOT) begin
                    if (load_last) begin
                        foreach (m_staged[k]) m_staged[k] = q[k];
                        m_pend = 1'b1;
                    end else begin
                        exp_err = 1'b1;
                    end
                    q.delete();
                end else if (load_last) begin
                    exp_err = 1'b1;
                    q.delete();
                end
            end
            exp_ready    = !m_pend;
            exp_rd_valid = rd_en;
            if (rd_en) begin
                for (int j = 0; j < NI; j++) exp_rd_data[j*8 +: 8] = m_active[int'(rd_row)*NI + j];
            end
        end
    end

    function automatic logic [255:0] pack_active();
        logic [255:0] v;
        foreach (m_active[k]) v[k*8 +: 8] = m_active[k];
        return v;
    endfunction

    logic [7:0] seq[TOT];

    function automatic logic [255:0] pack_seq();
        logic [255:0] v;
        foreach (seq[k]) v[k*8 +: 8] = seq[k];
        return v;
    endfunction

    int n_done_seen = 0;
    int n_err_seen  = 0;

    always @(negedge clk) begin
        check_eq("load_ready", load_ready, exp_ready);
        check_eq("load_done", load_done, exp_done);
        check_eq("load_err", load_err, exp_err);
        check_eq("rd_valid", rd_valid, exp_rd_valid);
        check_eq("rd_data", rd_data, exp_rd_data);
        check_eq("weights", weights, pack_active());
        if (load_done === 1'b1) n_done_seen++;
        if (load_err === 1'b1) n_err_seen++;
    end

    bit rand_rd = 1'b0;

    always begin
        @(posedge clk);
        #1;
        if (rand_rd) begin
            rd_en  = 1'($urandom);
            rd_row = 2'($urandom);
        end
    end

    // All drivers start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last, input logic abort,
                             input int max_gap);
        logic acc;
        acc = 1'b0;
        idle($urandom_range(max_gap, 0));
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        load_abort = abort;
        for (int w = 0; w < 20; w++) begin
            acc = load_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        check_eq("beat_accept", acc, 1'b1);
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_abort = 1'b0;
    endtask

    task automatic send_seq(input int n, input int last_idx, input int max_gap);
        for (int k = 0; k < n; k++) send_beat(seq[k], k == last_idx, 1'b0, max_gap);
    endtask

    int           d0, e0, n;
    logic [255:0] snap;
    logic [63:0]  exp_row;
    logic [79:0]  exp2, init2_v;

    initial begin
        init2_v = INIT2;
        idle(3);
        rst = 1'b0;
        idle(1);

        // Reset state and a read of row 2
        check_eq("rst_weights", weights, '0);
        check_eq("rst_ready", load_ready, 1'b1);
        check_eq("rst_weights2", weights2, init2_v);
        rd_en = 1'b1;
        rd_row = 2'd2;
        idle(1);
        rd_en = 1'b0;
        check_eq("rst_rd_valid", rd_valid, 1'b1);
        check_eq("rst_rd_data", rd_data, '0);

        // Full load of k with random gaps
        foreach (seq[k]) seq[k] = 8'(k);
        d0 = n_done_seen;
        e0 = n_err_seen;
        send_seq(TOT, TOT - 1, 3);
        check_eq("precommit_weights", weights, '0);
        idle(3);
        check_eq("load1_done_cnt", n_done_seen - d0, 1);
        check_eq("load1_err_cnt", n_err_seen - e0, 0);
        rd_en = 1'b1;
        rd_row = 2'd1;
        idle(1);
        rd_en = 1'b0;
        for (int j = 0; j < NI; j++) exp_row[j*8 +: 8] = 8'(8 + j);
        check_eq("load1_row1", rd_data, exp_row);

        // Premature last on beat 10, then a clean 0xEE load
        foreach (seq[k]) seq[k] = 8'($urandom);
        snap = weights;
        d0 = n_done_seen;
        e0 = n_err_seen;
        send_seq(11, 10, 2);
        idle(2);
        check_eq("shortlast_err_cnt", n_err_seen - e0, 1);
        check_eq("shortlast_weights", weights, snap);
        foreach (seq[k]) seq[k] = 8'hEE;
        send_seq(TOT, TOT - 1, 2);
        idle(3);
        check_eq("ee_done_cnt", n_done_seen - d0, 1);
        check_eq("ee_weights", weights, {32{8'hEE}});

        // Missing last, then abort after 5 beats, then abort with a same-cycle beat
        foreach (seq[k]) seq[k] = 8'($urandom);
        e0 = n_err_seen;
        send_seq(TOT, -1, 1);
        idle(2);
        check_eq("nolast_err_cnt", n_err_seen - e0, 1);
        check_eq("nolast_weights", weights, {32{8'hEE}});
        d0 = n_done_seen;
        e0 = n_err_seen;
        send_seq(5, -1, 1);
        load_abort = 1'b1;
        idle(1);
        load_abort = 1'b0;
        send_seq(3, -1, 0);
        send_beat(8'h5A, 1'b0, 1'b1, 0);
        idle(2);
        check_eq("abort_no_pulses", (n_done_seen - d0) + (n_err_seen - e0), 0);
        foreach (seq[k]) seq[k] = 8'($urandom);
        send_seq(TOT, TOT - 1, 1);
        idle(3);
        check_eq("postabort_done_cnt", n_done_seen - d0, 1);
        check_eq("postabort_weights", weights, pack_seq());

        // Read row 3 during the commit cycle
        foreach (seq[k]) seq[k] = 8'($urandom);
        send_seq(TOT, TOT - 1, 2);
        check_eq("commit_ready", load_ready, 1'b0);
        rd_en = 1'b1;
        rd_row = 2'd3;
        idle(1);
        rd_en = 1'b0;
        snap = pack_seq();
        check_eq("commit_rd_valid", rd_valid, 1'b1);
        check_eq("commit_rd_row3", rd_data, snap[3*64 +: 64]);

        // Second instance: load, then in-range and out-of-range reads
        for (int k = 0; k < 10; k++) begin
            l2_valid = 1'b1;
            l2_data  = 8'(8'h30 + k);
            l2_last  = (k == 9);
            exp2[k*8 +: 8] = 8'(8'h30 + k);
            idle(1);
        end
        l2_valid = 1'b0;
        l2_last  = 1'b0;
        idle(3);
        check_eq("dut2_weights", weights2, exp2);
        rd2_en = 1'b1;
        rd2_row = 3'd5;
        idle(1);
        check_eq("dut2_row5_valid", rd2_valid, 1'b1);
        check_eq("dut2_row5_data", rd2_data, '0);
        rd2_row = 3'd4;
        idle(1);
        rd2_en = 1'b0;
        check_eq("dut2_row4_data", rd2_data, exp2[64 +: 16]);

        // Random mix of well-formed, short, overlong and aborted loads with random reads
        rand_rd = 1'b1;
        for (int it = 0; it < 40; it++) begin
            foreach (seq[k]) seq[k] = 8'($urandom);
            case ($urandom_range(3, 0))
                0: send_seq(TOT, TOT - 1, 3);
                1: begin
                    n = $urandom_range(TOT - 1, 1);
                    send_seq(n, n - 1, 2);
                end
                2: send_seq(TOT, -1, 2);
                default: begin
                    send_seq($urandom_range(TOT - 1, 0), -1, 2);
                    send_beat(8'($urandom), 1'b0, 1'b1, 2);
                end
            endcase
        end
        rand_rd = 1'b0;
        idle(1);
        rd_en = 1'b0;
        idle(3);

        // Reset in the middle of a load
        foreach (seq[k]) seq[k] = 8'(k + 1);
        d0 = n_done_seen;
        send_seq(20, -1, 1);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(3);
        check_eq("midrst_weights", weights, '0);
        check_eq("midrst_done_cnt", n_done_seen - d0, 0);
        check_eq("midrst_ready", load_ready, 1'b1);
        check_eq("midrst_weights2", weights2, init2_v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
